// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the single-clock FIFO slice: default geometry,
// the depth calculation and the wrapping pointer increment.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Number of storage entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Increment a ptr_w-bit pointer modulo 2**ptr_w. Pointers carry one bit
  // more than the RAM address, so the extra MSB toggles on every wrap.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
// Bundles the FIFO request/response signals.
//   master : drives wr_en, wdata, rd_en, flush, clr_err; observes the rest
//   slave  : the FIFO side; returns rdata/rvalid, level flags, count, errors
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              flush;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wdata, rd_en, flush, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, flush, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_dpram.sv
// fifo_dpram
// Simple dual-port RAM, one write port and one registered read port.
//   clk   : single clock
//   rst_n : async active-low reset, clears only the read data register
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = int'(fifo_depth(ADDR_W));

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value whenever no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock parametrised FIFO around fifo_dpram.
//   clk   : rising-edge clock
//   rst_n : async active-low reset
//   bus   : slave modport carrying write/read requests, flush, clr_err,
//           registered read data with rvalid pulse, level flags,
//           occupancy count and sticky overflow/underflow
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
)(
  input logic                clk,
  input logic                rst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int              PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(fifo_depth(ADDR_W));
  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0]  wptr, rptr, count;
  logic              rvalid_q, overflow_q, underflow_q;
  logic              full_w, empty_w, wr_acc, rd_acc;
  logic [DATA_W-1:0] rdata_q;

  // Flags come straight from the registered count.
  assign full_w  = (count == DEPTH_C);
  assign empty_w = (count == '0);

  // Flush overrides both requests so nothing touches the RAM that cycle.
  assign wr_acc = bus.wr_en & ~full_w  & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty_w & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= PTR_W'(ptr_inc(32'(wptr), PTR_W));
      if (rd_acc) rptr <= PTR_W'(ptr_inc(32'(rptr), PTR_W));
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
      rvalid_q <= rd_acc;
      // A new error event in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full_w)      overflow_q  <= 1'b1;
      else if (bus.clr_err)         overflow_q  <= 1'b0;
      if (bus.rd_en && empty_w)     underflow_q <= 1'b1;
      else if (bus.clr_err)         underflow_q <= 1'b0;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (bus.wdata),
    .re    (rd_acc),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (rdata_q)
  );

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count >= AFULL_C);
  assign bus.almost_empty = (count <= AEMPTY_C);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO built around a dual-port RAM with a registered read port.
- Successor to the fixed 8-bit x 256 RAM in the async FIFO path. Adds:
  - generic width and depth;
  - internal pointer and flag generation;
  - occupancy count and almost-full/almost-empty thresholds;
  - sticky overflow/underflow errors;
  - synchronous flush.
- Used as the buffering element inside a single clock domain. Sits in front of or behind the CDC FIFO.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 4, address width. Depth = 2**ADDR_W (16 by default).
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (range 1..2**ADDR_W).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (range 0..2**ADDR_W-1).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wdata  in  DATA_W  write data.
- rd_en  in  1  read request.
- rdata  out  DATA_W  read data, registered.
- rvalid  out  1  one-cycle pulse marking rdata valid.
- flush  in  1  synchronous clear of pointers, count and errors.
- clr_err  in  1  synchronous clear of the sticky error flags.
- full  out  1  count == 2**ADDR_W.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr, count, rdata, rvalid, overflow, underflow, full, almost_full all go to 0.
  - empty and almost_empty go to 1 (almost_empty=1 because AEMPTY_TH >= 0).
  - RAM contents are not reset.
- Pointers:
  - wptr and rptr are ADDR_W+1 bits. The MSB is the wrap bit; the low ADDR_W bits address the RAM.
  - Each pointer increments modulo 2**(ADDR_W+1), so it wraps naturally.
- Write acceptance: wr_acc = wr_en & ~full. On the accepting edge, RAM[wptr[ADDR_W-1:0]] <= wdata and wptr increments.
- Read acceptance: rd_acc = rd_en & ~empty.
  - On the accepting edge, rdata <= RAM[rptr[ADDR_W-1:0]], rptr increments, and rvalid=1 for exactly the next cycle. Latency is 1 cycle.
  - rdata holds its last value when no read is accepted.
- Flags: full, empty, almost_full and almost_empty are decoded from registered count. They reflect an accepted operation in the cycle after its edge.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted in the same cycle.
- Simultaneous write and read:
  - When full, the write is rejected even if a read is accepted in the same cycle. Overflow is set; count drops to 2**ADDR_W-1.
  - When empty, the read is rejected; no read-through of the incoming write. Underflow is set; count rises to 1.
- Errors:
  - overflow <= 1 on wr_en & full.
  - underflow <= 1 on rd_en & empty.
  - Both flags hold until clr_err or flush. If clr_err and a new error event occur in the same cycle, the set wins.
- flush (synchronous, highest priority over wr_en and rd_en that cycle):
  - wptr=rptr=0, count=0, overflow=underflow=0, rvalid=0.
  - rdata holds its value. RAM is untouched.
- RAM wrap: after 2**ADDR_W writes, addresses wrap to 0 while the pointer MSB toggles. full is still derived from count, so wrap-around is transparent.
- Reset asserted mid-operation: state is immediately forced to reset values. In-flight data is discarded and no rvalid follows.

Decomposition:
- Shared package fifo_pkg holds:
  - the depth function (2**ADDR_W);
  - localparams for default DATA_W/ADDR_W;
  - the pointer-increment helper.
- Sub-module fifo_dpram holds the storage:
  - parametrised DATA_W/ADDR_W;
  - one write port (we, waddr, wdata);
  - one registered read port (re, raddr, rdata);
  - a single clk.
- sync_fifo_param holds pointers, count, flags and error logic, and instantiates one fifo_dpram.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high. Expect empty=1, almost_empty=1, full=0, count=0, rdata=0, overflow=underflow=0.
- Fill and drain, defaults: write 0x00..0x0F on 16 consecutive cycles.
  - Expect almost_full to rise after the 12th write and full after the 16th; count=16.
  - Then read 16 times: rdata=0x00..0x0F in order, each one cycle after its rd_en, with rvalid pulsing. empty=1 after the last read.
- Overflow/underflow:
  - When full, write 0xAA: overflow=1, count stays 16, and 0xAA is never read out.
  - When empty, read: underflow=1, rvalid=0.
  - Assert clr_err: both flags clear.
- Simultaneous ops:
  - At count=5, wr_en=rd_en=1 for 4 cycles: count stays 5, outputs come in FIFO order.
  - When full with both asserted: count goes to 15 and overflow=1.
- Wrap-around: 40 writes interleaved with reads, keeping count between 3 and 10. Every rdata matches a scoreboard, and pointers wrap past 31 with no data loss.
- Flush and mid-operation reset:
  - At count=9, pulse flush: count=0, empty=1, errors cleared; the next write/read returns the new data.
  - Repeat with rst_n dropped mid-burst: flags are immediately at their reset values and no rvalid follows.
